// File: rtl/md_seq_pkg.sv
// Shared definitions for the mult/div sequencer.
//   md_state_e : sequencer FSM encoding (2 bits)
//   md_op_e    : latched operation kind
//   defaults for the rstatus target register, exception codes and WAIT timeout
//   exc_code() : selects the rstatus code for an operation
package md_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } md_state_e;

  typedef enum logic {
    OpMult = 1'b0,
    OpDiv  = 1'b1
  } md_op_e;

  localparam int unsigned RstatusReg     = 30;
  localparam int unsigned MultExcCodeDef = 4;
  localparam int unsigned DivExcCodeDef  = 5;
  localparam int unsigned TimeoutDef     = 64;

  // Zero-extended code written to rstatus when the operation raises an exception.
  function automatic logic [31:0] exc_code(input md_op_e      op,
                                           input int unsigned mult_code,
                                           input int unsigned div_code);
    logic [31:0] code;
    code = (op == OpMult) ? mult_code : div_code;
    return code;
  endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// WAIT-state watchdog for the mult/div sequencer.
// Ports:
//   clk_i     : clock, rising edge
//   clear_i   : synchronous clear (held while the sequencer is outside WAIT, and on reset)
//   en_i      : count one WAIT cycle
//   expired_o : high during the Timeout-th enabled cycle since the last clear
// Timeout must be >= 2.
module md_timeout_counter #(
  parameter int unsigned Timeout = 64
) (
  input  logic clk_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned     CntW    = $clog2(Timeout);
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences the multi-cycle mult/div unit for the 5-stage pipeline.
// A mult/div in DX is accepted, the unit is started with a one-cycle pulse, and PC/FD/DX are
// frozen (bubbles into XM) until the result is back. The result then waits for the regfile write
// port (MW has priority) and the instruction retires as a nop. Exceptions write a fixed code to
// rstatus instead of the destination.
//
// Optional feature: define MULTDIV_TIMEOUT_EN to force an exception after TIMEOUT WAIT cycles
// without a result. Without it WAIT lasts until md_resultRDY.
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   DX_isMult / DX_isDiv  : DX holds a mult / div (mult wins if both)
//   DX_rd, DX_A, DX_B     : destination and bypassed operands at DX
//   MW_regWrite           : MW owns the regfile write port this cycle
//   md_resultRDY          : unit result valid pulse, with md_result / md_exception
//   ctrl_MULT / ctrl_DIV  : one-cycle start pulses to the unit
//   md_A, md_B            : operands latched at accept
//   stall                 : freeze PC/FD/DX, inject nop into XM
//   wb_en, wb_rd, wb_data : regfile write from the sequencer (all zero when not writing)
//   md_retire             : DX instruction leaves as a nop this cycle
module multdiv_sequencer
  import md_seq_pkg::*;
#(
  parameter int unsigned RSTATUS_REG   = RstatusReg,
  parameter int unsigned MULT_EXC_CODE = MultExcCodeDef,
  parameter int unsigned DIV_EXC_CODE  = DivExcCodeDef,
  parameter int unsigned TIMEOUT       = TimeoutDef
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        DX_isMult,
  input  logic        DX_isDiv,
  input  logic [4:0]  DX_rd,
  input  logic [31:0] DX_A,
  input  logic [31:0] DX_B,
  input  logic        MW_regWrite,
  input  logic        md_resultRDY,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_A,
  output logic [31:0] md_B,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        md_retire
);

  md_state_e   state_q, state_d;
  md_op_e      op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        timeout_expired;

`ifdef MULTDIV_TIMEOUT_EN
  logic timeout_clear;
  logic timeout_en;

  // Held clear outside WAIT, so the count always starts from zero on WAIT entry.
  assign timeout_clear = reset || (state_q != StWait);
  assign timeout_en    = (state_q == StWait);

  md_timeout_counter #(
    .Timeout (TIMEOUT)
  ) u_timeout_counter (
    .clk_i     (clock),
    .clear_i   (timeout_clear),
    .en_i      (timeout_en),
    .expired_o (timeout_expired)
  );
`else
  logic unused_timeout;

  assign timeout_expired = 1'b0;
  assign unused_timeout  = ^TIMEOUT;
`endif

  assign md_A = a_q;
  assign md_B = b_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    exc_d     = exc_q;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = 1'b0;
    wb_en     = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    md_retire = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (DX_isMult || DX_isDiv) begin
          op_d    = DX_isMult ? OpMult : OpDiv;
          rd_d    = DX_rd;
          a_d     = DX_A;
          b_d     = DX_B;
          // Freeze DX in the accept cycle itself so the instruction is not lost.
          stall   = 1'b1;
          state_d = StStart;
        end
      end

      StStart: begin
        stall     = 1'b1;
        ctrl_MULT = (op_q == OpMult);
        ctrl_DIV  = (op_q == OpDiv);
        // A result can not coincide with its own start pulse; any RDY here is ignored.
        state_d   = StWait;
      end

      StWait: begin
        stall = 1'b1;
        if (md_resultRDY) begin
          result_d = md_result;
          exc_d    = md_exception;
          state_d  = StDone;
        end else if (timeout_expired) begin
          exc_d   = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        if (MW_regWrite) begin
          // MW owns the write port; hold the pipeline until it frees up.
          stall = 1'b1;
        end else begin
          md_retire = 1'b1;
          state_d   = StIdle;
          if (exc_q) begin
            wb_en   = 1'b1;
            wb_rd   = 5'(RSTATUS_REG);
            wb_data = exc_code(op_q, MULT_EXC_CODE, DIV_EXC_CODE);
          end else if (rd_q != 5'd0) begin
            wb_en   = 1'b1;
            wb_rd   = rd_q;
            wb_data = result_q;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
`timescale 1ns/1ps
module tb_multdiv_sequencer;

  localparam int unsigned Timeout = 8;

  logic        clock;
  logic        reset;
  logic        DX_isMult;
  logic        DX_isDiv;
  logic [4:0]  DX_rd;
  logic [31:0] DX_A;
  logic [31:0] DX_B;
  logic        MW_regWrite;
  logic        md_resultRDY;
  logic [31:0] md_result;
  logic        md_exception;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] md_A;
  logic [31:0] md_B;
  logic        stall;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        md_retire;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  typedef struct {
    bit          is_mult;
    bit          is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    int          wait_n;   // unit latency after start pulse; 0 = never answers
    int          mw_n;     // MW_regWrite cycles after the result
    bit          exc;
    bit          early;    // spurious RDY in the start-pulse cycle
    bit          exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  typedef struct {
    int          stall_n;
    int          mult_n;
    int          div_n;
    int          pulse_c;
    int          ret_c;
    int          viol;
    bit          retired;
    int unsigned pulse_abs;
    int unsigned ret_abs;
    logic [31:0] a_seen;
    logic [31:0] b_seen;
    bit          wb_en_s;
    logic [4:0]  wb_rd_s;
    logic [31:0] wb_data_s;
  } obs_t;

  multdiv_sequencer #(
    .TIMEOUT (Timeout)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .DX_isMult    (DX_isMult),
    .DX_isDiv     (DX_isDiv),
    .DX_rd        (DX_rd),
    .DX_A         (DX_A),
    .DX_B         (DX_B),
    .MW_regWrite  (MW_regWrite),
    .md_resultRDY (md_resultRDY),
    .md_result    (md_result),
    .md_exception (md_exception),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_A         (md_A),
    .md_B         (md_B),
    .stall        (stall),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .md_retire    (md_retire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit m, input bit d, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input bit rdy, input bit exc,
                       input logic [31:0] res, input bit mw);
    DX_isMult    = m;
    DX_isDiv     = d;
    DX_rd        = rd;
    DX_A         = a;
    DX_B         = b;
    md_resultRDY = rdy;
    md_exception = exc;
    md_result    = res;
    MW_regWrite  = mw;
  endtask

  function automatic vec_t mk(input bit m, input bit d, input logic [4:0] rd,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input int w, input int mw,
                              input bit exc, input bit early, input bit een,
                              input logic [4:0] erd, input logic [31:0] edata, input int estall);
    vec_t v;
    v.is_mult = m;    v.is_div = d;      v.rd = rd;       v.a = a;         v.b = b;
    v.result = res;   v.wait_n = w;      v.mw_n = mw;     v.exc = exc;     v.early = early;
    v.exp_en = een;   v.exp_rd = erd;    v.exp_data = edata;               v.exp_stall = estall;
    return v;
  endfunction

  // Reference: stalled for accept + start + every WAIT cycle + every DONE cycle MW holds the
  // port; then one retire cycle with the writeback decided by the exception / rd==0 rules.
  function automatic vec_t model(input vec_t v);
    int waits = v.wait_n;
    int mw    = v.mw_n;
    bit exc   = v.exc;
`ifdef MULTDIV_TIMEOUT_EN
    if (v.wait_n == 0 || v.wait_n > int'(Timeout)) begin
      waits = int'(Timeout);
      mw    = 0;
      exc   = 1'b1;
    end
`endif
    v.exp_stall = 2 + waits + mw;
    if (exc) begin
      v.exp_en   = 1'b1;
      v.exp_rd   = 5'd30;
      v.exp_data = v.is_mult ? 32'd4 : 32'd5;
    end else if (v.rd == 5'd0) begin
      v.exp_en   = 1'b0;
      v.exp_rd   = 5'd0;
      v.exp_data = 32'd0;
    end else begin
      v.exp_en   = 1'b1;
      v.exp_rd   = v.rd;
      v.exp_data = v.result;
    end
    return v;
  endfunction

  // Holds the instruction in DX and plays the unit / MW side until retire or max_cycles.
  task automatic run_op(input vec_t v, input int max_cycles, output obs_t o);
    int          pulse = -1;
    int          rdy_c = -1;
    bit          rdy;
    bit          mw;
    bit          exc_in;
    logic [31:0] res_in;
    o = '{default: 0};
    o.pulse_c = -1;
    for (int c = 0; c < max_cycles && !o.retired; c++) begin
      tick();
      rdy    = 1'b0;
      exc_in = 1'($urandom_range(0, 1));
      res_in = $urandom;
      if (v.early && c == 1) rdy = 1'b1;
      if (pulse >= 0 && v.wait_n > 0 && c == pulse + v.wait_n) begin
        rdy    = 1'b1;
        exc_in = v.exc;
        res_in = v.result;
        rdy_c  = c;
      end
      mw = (rdy_c >= 0) && (c > rdy_c) && (c <= rdy_c + v.mw_n);
      drive(v.is_mult, v.is_div, v.rd, v.a, v.b, rdy, exc_in, res_in, mw);
      @(negedge clock);
      if (stall) o.stall_n++;
      if (ctrl_MULT) o.mult_n++;
      if (ctrl_DIV) o.div_n++;
      if ((ctrl_MULT || ctrl_DIV) && pulse < 0) begin
        pulse       = c;
        o.pulse_c   = c;
        o.pulse_abs = cyc;
        o.a_seen    = md_A;
        o.b_seen    = md_B;
      end
      if (wb_en && MW_regWrite) o.viol++;
      if (!wb_en && (wb_rd != 5'd0 || wb_data != 32'd0)) o.viol++;
      if (wb_en && !md_retire) o.viol++;
      if (c >= 1 && (md_A !== v.a || md_B !== v.b)) o.viol++;
      if (md_retire) begin
        o.retired   = 1'b1;
        o.ret_c     = c;
        o.ret_abs   = cyc;
        o.wb_en_s   = wb_en;
        o.wb_rd_s   = wb_rd;
        o.wb_data_s = wb_data;
        if (stall) o.viol++;
      end
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v, input obs_t o);
    check({tag, " retired"}, 32'(o.retired), 32'd1);
    check({tag, " stall cycles"}, o.stall_n, v.exp_stall);
    check({tag, " retire cycle"}, o.ret_c, v.exp_stall);
    check({tag, " mult pulses"}, o.mult_n, v.is_mult ? 1 : 0);
    check({tag, " div pulses"}, o.div_n, v.is_mult ? 0 : 1);
    check({tag, " pulse cycle"}, o.pulse_c, 1);
    check({tag, " md_A"}, o.a_seen, v.a);
    check({tag, " md_B"}, o.b_seen, v.b);
    check({tag, " wb_en"}, 32'(o.wb_en_s), 32'(v.exp_en));
    check({tag, " wb_rd"}, 32'(o.wb_rd_s), 32'(v.exp_rd));
    check({tag, " wb_data"}, o.wb_data_s, v.exp_data);
    check({tag, " protocol"}, o.viol, 0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    vec_t v2;
    obs_t o;
    obs_t o2;
    int   nz;
    int   sel;

    reset = 1'b1;
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    repeat (3) @(posedge clock);
    #1;
    drive(1, 0, 5'd3, 32'd1, 32'd2, 0, 0, 32'd0, 0);
    @(negedge clock);
    // Held in reset: nothing accepted, so a mult in DX must not stall yet.
    tick();
    drive(0, 0, 5'd0, 32'd0, 32'd0, 1, 1, 32'hffff_ffff, 0);
    @(negedge clock);
    check("reset stall", 32'(stall), 32'd0);
    check("reset ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check("reset wb", 32'(wb_en) | 32'(wb_rd) | wb_data, 32'd0);
    check("reset retire", 32'(md_retire), 32'd0);
    check("reset operands", md_A | md_B, 32'd0);
    tick();
    reset = 1'b0;
    drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    @(negedge clock);
    check("idle stall", 32'(stall), 32'd0);

    // Directed table
    tbl.push_back(mk(1, 0, 5'd5, 32'd6, 32'd7, 32'd42, 3, 0, 0, 0, 1, 5'd5, 32'd42, 5));
    tbl.push_back(mk(0, 1, 5'd9, 32'd100, 32'd0, 32'h1234, 2, 2, 1, 0, 1, 5'd30, 32'd5, 6));
    tbl.push_back(mk(1, 0, 5'd0, 32'd3, 32'd3, 32'd9, 1, 0, 0, 0, 0, 5'd0, 32'd0, 3));
    tbl.push_back(mk(1, 0, 5'd0, 32'hffff_ffff, 32'd2, 32'd0, 1, 0, 1, 0, 1, 5'd30, 32'd4, 3));
    tbl.push_back(mk(1, 1, 5'd3, 32'd2, 32'd5, 32'hdead, 2, 0, 0, 0, 1, 5'd3, 32'hdead, 4));
    tbl.push_back(mk(0, 1, 5'd31, 32'd50, 32'd5, 32'd10, 1, 0, 0, 1, 1, 5'd31, 32'd10, 3));
    tbl.push_back(mk(0, 1, 5'd0, 32'd7, 32'd0, 32'd0, 4, 1, 1, 0, 1, 5'd30, 32'd5, 7));
`ifdef MULTDIV_TIMEOUT_EN
    tbl.push_back(mk(1, 0, 5'd12, 32'd1, 32'd1, 32'd0, 0, 0, 0, 0, 1, 5'd30, 32'd4, 10));
    tbl.push_back(mk(0, 1, 5'd12, 32'd1, 32'd1, 32'd0, 0, 0, 0, 0, 1, 5'd30, 32'd5, 10));
    tbl.push_back(mk(1, 0, 5'd12, 32'd3, 32'd4, 32'd12, 8, 0, 0, 0, 1, 5'd12, 32'd12, 10));
`endif
    foreach (tbl[i]) begin
      run_op(tbl[i], 300, o);
      check_vec($sformatf("vec%0d", i), tbl[i], o);
    end

    // Back-to-back: second accepted the cycle after retire, pulsed the cycle after that.
    v  = mk(1, 0, 5'd1, 32'd2, 32'd3, 32'd11, 2, 0, 0, 0, 1, 5'd1, 32'd11, 4);
    v2 = mk(1, 0, 5'd2, 32'd4, 32'd5, 32'd22, 1, 1, 0, 0, 1, 5'd2, 32'd22, 4);
    run_op(v, 300, o);
    run_op(v2, 300, o2);
    check_vec("b2b first", v, o);
    check_vec("b2b second", v2, o2);
    check("b2b pulse spacing", o2.pulse_abs - o.ret_abs, 32'd2);

    // Reset while in WAIT, then a stale RDY two cycles later.
    tick(); drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick(); drive(1, 0, 5'd7, 32'd8, 32'd9, 0, 0, 32'd0, 0);
    tick(); drive(1, 0, 5'd7, 32'd8, 32'd9, 0, 0, 32'd0, 0);
    tick(); drive(1, 0, 5'd7, 32'd8, 32'd9, 0, 0, 32'd0, 0);
    tick(); reset = 1'b1; drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
    tick(); reset = 1'b0;
    nz = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        tick();
        drive(0, 0, 5'd0, 32'd0, 32'd0, k == 1, 0, 32'd99, 0);
      end
      @(negedge clock);
      if (stall || ctrl_MULT || ctrl_DIV || wb_en || md_retire || wb_rd != 5'd0 ||
          wb_data != 32'd0 || md_A != 32'd0 || md_B != 32'd0) nz++;
    end
    check("reset abort outputs", nz, 0);
    run_op(tbl[0], 300, o);
    check_vec("post-reset", tbl[0], o);

`ifndef MULTDIV_TIMEOUT_EN
    // No timeout: WAIT holds for as long as the unit is silent.
    v = mk(1, 0, 5'd12, 32'd1, 32'd2, 32'd0, 0, 0, 0, 0, 0, 5'd0, 32'd0, 0);
    run_op(v, 120, o);
    check("long wait stall", o.stall_n, 120);
    check("long wait no retire", 32'(o.retired), 32'd0);
    tick(); drive(1, 0, 5'd12, 32'd1, 32'd2, 1, 0, 32'h77, 0);
    @(negedge clock);
    tick(); drive(1, 0, 5'd12, 32'd1, 32'd2, 0, 0, 32'd0, 0);
    @(negedge clock);
    check("late retire", 32'(md_retire), 32'd1);
    check("late wb_rd", 32'(wb_rd), 32'd12);
    check("late wb_data", wb_data, 32'h77);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 3);
      v = mk(sel != 2, sel >= 2,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom, $urandom,
             $urandom_range(1, 6), $urandom_range(0, 3),
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             0, 5'd0, 32'd0, 0);
      v = model(v);
      run_op(v, 300, o);
      check_vec($sformatf("rand%0d", i), v, o);
      repeat ($urandom_range(0, 2)) begin
        tick();
        drive(0, 0, 5'd0, 32'd0, 32'd0, 0, 0, 32'd0, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
